// File: rtl/alu_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_ctrl_if
// Description : Instruction valid/ready handshake between the issuing master
//               and the alu_seq_ctrl sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_ctrl_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [11:0] instr;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);
endinterface
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_ctrl
// Description : Four-state sequencer in front of a combinational 16-bit ALU.
//               Owns the register file and Z/N/C flags, reads operands,
//               captures the ALU response and writes it back.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl #(
  parameter int DW = 16,
  parameter int RA = 3
) (
  input  logic          clk,
  input  logic          rst,
  alu_seq_ctrl_if.slave ibus,
  input  logic          ld_en,
  input  logic [RA-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic [RA-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic [DW-1:0] aluA,
  output logic [DW-1:0] aluB,
  output logic          aluC,
  output logic [2:0]    aluOpc,
  input  logic [DW-1:0] aluW,
  input  logic          aluZer,
  input  logic          aluNeg,
  output logic [DW-1:0] result,
  output logic          flagZ,
  output logic          flagN,
  output logic          flagC,
  output logic          done,
  output logic          busy
);

  localparam logic [2:0] c_OPC_ADD = 3'b010;
  localparam logic [2:0] c_OPC_NOP = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t          r_state;
  logic [11:0]     r_instr;
  logic [DW-1:0]   r_rf [2**RA];
  logic [DW-1:0]   r_alu_a;
  logic [DW-1:0]   r_alu_b;
  logic [2:0]      r_alu_opc;
  logic [DW-1:0]   r_held_w;
  logic            r_held_z;
  logic            r_held_n;
  logic            r_held_c;
  logic [DW-1:0]   r_result;
  logic            r_flag_z;
  logic            r_flag_n;
  logic            r_flag_c;
  logic            r_done;

  logic [2:0]      w_opc;
  logic [RA-1:0]   w_dst;
  logic [RA-1:0]   w_src_a;
  logic [RA-1:0]   w_src_b;
  logic [DW:0]     w_sum;
  logic            w_accept;

  // Instruction field decode from the latched instruction word
  assign w_opc   = r_instr[11:9];
  assign w_dst   = r_instr[6 +: RA];
  assign w_src_a = r_instr[3 +: RA];
  assign w_src_b = r_instr[0 +: RA];

  // Carry-out is bit DW of the widened operand sum including carry-in
  assign w_sum    = {1'b0, r_alu_a} + {1'b0, r_alu_b} + {{DW{1'b0}}, r_flag_c};
  assign w_accept = ibus.instr_valid && (r_state == S_IDLE);

  // Sequencer: state, register file, ALU operand drive, capture and writeback
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_instr   <= '0;
      for (int i = 0; i < 2**RA; i++) r_rf[i] <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_opc <= '0;
      r_held_w  <= '0;
      r_held_z  <= 1'b0;
      r_held_n  <= 1'b0;
      r_held_c  <= 1'b0;
      r_result  <= '0;
      r_flag_z  <= 1'b0;
      r_flag_n  <= 1'b0;
      r_flag_c  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Loads only land while idle, so READ of a same-cycle accept sees them
          if (ld_en) r_rf[ld_addr] <= ld_data;
          if (w_accept) begin
            r_instr <= ibus.instr;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          r_alu_a   <= r_rf[w_src_a];
          r_alu_b   <= r_rf[w_src_b];
          r_alu_opc <= w_opc;
          r_state   <= S_EXEC;
        end
        S_EXEC: begin
          r_held_w <= aluW;
          r_held_z <= aluZer;
          r_held_n <= aluNeg;
          r_held_c <= w_sum[DW];
          r_done   <= 1'b1;
          r_state  <= S_WB;
        end
        S_WB: begin
          if (w_opc != c_OPC_NOP) begin
            r_rf[w_dst] <= r_held_w;
            r_result    <= r_held_w;
            r_flag_z    <= r_held_z;
            r_flag_n    <= r_held_n;
          end
          if (w_opc == c_OPC_ADD) r_flag_c <= r_held_c;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ibus.instr_ready = (r_state == S_IDLE);
  assign busy             = (r_state != S_IDLE);
  assign done             = r_done;
  assign rd_data          = r_rf[rd_addr];
  assign aluA             = r_alu_a;
  assign aluB             = r_alu_b;
  assign aluOpc           = r_alu_opc;
  assign aluC             = r_flag_c;
  assign result           = r_result;
  assign flagZ            = r_flag_z;
  assign flagN            = r_flag_n;
  assign flagC            = r_flag_c;

endmodule
`default_nettype wire

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Sequencing controller that sits directly upstream of the 16-bit ALU. It owns an 8x16 register file and Z/N/C flag registers. It accepts register-to-register instructions over a valid/ready handshake, drives the ALU operands, opcode and carry-in, and captures the ALU result and flags. It then writes the result back into the register file on a fixed multi-cycle schedule.

Parameters:
- DW, 16, datapath width; matches the ALU operand width.
- RA, 3, register address width; the register file has 2**RA entries.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- instr_valid  input  1  instruction offered
- instr_ready  output  1  controller can accept; high only in IDLE
- instr  input  12  {opc[11:9], dst[8:6], srcA[5:3], srcB[2:0]}
- ld_en  input  1  external register load strobe
- ld_addr  input  RA  load address
- ld_data  input  DW  load data
- rd_addr  input  RA  debug read address
- rd_data  output  DW  combinational read of regfile[rd_addr]
- aluA  output  DW  registered operand A to ALU
- aluB  output  DW  registered operand B to ALU
- aluC  output  1  carry-in to ALU; equals C flag register
- aluOpc  output  3  registered opcode to ALU
- aluW  input  DW  ALU result
- aluZer  input  1  ALU zero flag
- aluNeg  input  1  ALU negative flag
- result  output  DW  last written-back value
- flagZ, flagN, flagC  output  1 each  architectural flags
- done  output  1  one-cycle pulse when an instruction retires
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, any state):
  - state = IDLE.
  - All regfile entries, aluA, aluB, aluOpc, result and flags = 0.
  - done = 0, busy = 0, instr_ready = 1.
- FSM: IDLE -> READ -> EXEC -> WB -> IDLE. No other transitions; no stalls once an instruction is accepted.
- IDLE:
  - The instruction is accepted on the cycle (cycle 0) where instr_valid & instr_ready; instr is latched internally.
  - Without acceptance, stay in IDLE.
- READ (cycle 1): aluA <= regfile[srcA], aluB <= regfile[srcB], aluOpc <= opc.
- EXEC (cycle 2):
  - The ALU responds combinationally.
  - Capture aluW, aluZer and aluNeg into internal holding registers.
  - Compute carry-out internally as bit DW of the (DW+1)-bit unsigned sum aluA + aluB + aluC.
- WB (cycle 3):
  - If opc != 3'b111: regfile[dst] <= held W; result <= held W; flagZ <= held zer; flagN <= held neg.
  - flagC is updated only when opc == 3'b010; all other opcodes leave flagC unchanged.
  - opc 3'b111 is a NOP: no regfile write; result and all flags unchanged.
  - done = 1 for exactly this cycle, regardless of opcode.
- Retire latency: 3 cycles after acceptance. Back-to-back throughput: one instruction per 4 cycles; next acceptance no earlier than the cycle after WB.
- aluC always reflects the current flagC. A carry produced by an instruction is visible to the next instruction's READ/EXEC.
- External load port:
  - A load takes effect on the clock edge only when state == IDLE; ld_en in other states is ignored (dropped, not queued).
  - Load and instruction acceptance in the same IDLE cycle: the load is written first and the accepted instruction's READ sees the new value.
- dst equal to srcA or srcB is legal: the old value is read in READ and the new value is written in WB.
- rd_data is a combinational regfile read. A write in WB is visible on rd_data the cycle after.
- Reset asserted mid-instruction: the instruction is aborted; no writeback occurs and done does not pulse.
- All arithmetic is modulo 2**DW. Sign behaviour (negate, arithmetic shift) belongs to the ALU; the controller never alters aluW.

Test Plan:
- Load R1=0x0005, R2=0x0003; issue ADD (opc 010, dst 3, srcA 1, srcB 2) with C=0 -> done pulses at cycle 3 after acceptance; R3=0x0008; Z=0, N=0, C=0.
- Load R1=0xFFFF, R2=0x0001; ADD into R4 -> R4=0x0000, Z=1, C=1. Then ADD R0+R0 into R5 (R0=0) -> R5=0x0001 (carry-in used), C=0.
- R1=0x0005; NEG (opc 000, dst 6, srcA 1) -> R6=0xFFFB, N=1, Z=0, C unchanged. Then R1=0x1234, R2=0xABCD; CONCAT (opc 110) -> 0x34CD.
- NOP (opc 111, dst 3) after a prior write -> done pulses; R3, result and flags unchanged; instr_ready high again at cycle 4.
- ld_en to R7 during READ -> ignored; R7 unchanged. ld_en to R1 in the same IDLE cycle as an INC (opc 001, srcA 1) acceptance -> result = new R1 + 1.
- Assert rst during EXEC of an ADD into R3 -> no write, no done; after release all registers and flags read 0 and instr_ready = 1.
